codec_i2s_rx: RTL and testbench
===============================

CODEC_I2S_RX -- requirements
Module: codec_i2s_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, 16, captured bits per channel (MSB first).
REQ-002 SHALL have parameter SLOT_BITS, 32, bclk periods per channel slot (LRCK half-period); must be at least DATA_BITS+1.
REQ-003 SHALL have port bclk  input  1  codec bit clock; all logic on its rising edge.
REQ-004 SHALL have port req_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc_lrck_i  input  1  codec word clock (low = left, high = right).
REQ-006 SHALL have port adc_dat_i  input  1  codec serial data, changes on falling bclk.
REQ-007 SHALL have port sample_data_L_o  output  DATA_BITS  last complete left sample.
REQ-008 SHALL have port sample_data_R_o  output  DATA_BITS  last complete right sample.
REQ-009 SHALL have port data_ready_o  output  1  one-bclk pulse: new L/R pair valid.
REQ-010 SHALL have port frame_err_o  output  1  one-bclk pulse: short channel slot detected.

Function
REQ-011 SHALL register adc_lrck_i each rising bclk into lrck_q; edge = (adc_lrck_i != lrck_q).
REQ-012 SHALL implement FSM states IDLE, LEFT, RIGHT, WAIT_L, WAIT_R.
REQ-013 IDLE SHALL ignore data until a falling LRCK edge, then go to LEFT with bit counter 0.
REQ-014 Edge cycle SHALL be the I2S delay bit; MSB SHALL be sampled on the next rising bclk.
REQ-015 LEFT/RIGHT SHALL shift adc_dat_i into a DATA_BITS shift register, MSB first, counter +1 per cycle.
REQ-016 After the DATA_BITS-th bit, LEFT SHALL go to WAIT_L and RIGHT to WAIT_R; bits beyond DATA_BITS are discarded.
REQ-017 WAIT_L SHALL go to RIGHT on a rising LRCK edge; WAIT_R SHALL go to LEFT on a falling edge.
REQ-018 Completed left word SHALL be held internally; outputs SHALL NOT change until the right word completes.
REQ-019 The cycle after the right word's last bit, sample_data_L_o/R_o SHALL update and data_ready_o SHALL be 1 for exactly one cycle.
REQ-020 Outputs SHALL hold between pulses; data_ready_o pulses SHALL be at least 2*SLOT_BITS bclk apart at steady state.
REQ-021 A right word without a preceding complete left word in the same frame SHALL NOT produce data_ready_o.
REQ-022 An edge in the wrong polarity for the current WAIT state SHALL send the FSM to IDLE, no pulse.
REQ-023 Bit counter SHALL be $clog2(DATA_BITS+1) bits wide and never wrap.

Reset
REQ-024 On req_rstn low: state IDLE, counter 0, shift/hold registers 0, all outputs 0, lrck_q 0.
REQ-025 Reset asserted mid-frame SHALL abort the capture; no data_ready_o pulse for the partial frame after release.
REQ-026 After release, capture SHALL restart only at the next falling LRCK edge.

Configuration
REQ-027 Macro CODEC_I2S_RX_FRAME_CHECK_EN SHALL control short-slot detection.
REQ-028 Defined: an LRCK edge in LEFT/RIGHT before DATA_BITS bits SHALL pulse frame_err_o one cycle, discard the frame and go to IDLE.
REQ-029 Undefined: same edge SHALL silently discard the frame and go to IDLE; frame_err_o tied 0.

Structure
REQ-030 DATA_BITS default and FSM state encodings SHALL live in the shared codec package.
REQ-031 LRCK registering and edge detection SHALL be sub-module codec_lrck_edge (outputs rise, fall pulses).

Verification
REQ-032 L=0x1234, R=0xABCD, SLOT_BITS=32 -> one pulse; L_o=0x1234, R_o=0xABCD, one cycle after R bit 0.
REQ-033 Reset released with LRCK high mid-right-slot -> no pulse until the first full left+right frame completes.
REQ-034 Frames 0x8000/0x7FFF then 0xFFFF/0x0001 back-to-back -> two pulses 64 bclk apart with the correct pairs.
REQ-035 LRCK toggles after 10 left bits, macro defined -> frame_err_o pulse, no data_ready_o, recovery on next frame.
REQ-036 req_rstn low for 3 cycles mid-left-word -> outputs 0, no pulse, next full frame captured correctly.
REQ-037 Trailing bits 17..32 all ones after data 0x0F0F -> output 0x0F0F (trailing bits ignored).

Source files
------------

// File: rtl/codec_i2s_rx_pkg.sv
// Shared codec package: default sample width, slot length and receiver FSM states.
package codec_i2s_rx_pkg;

    localparam int unsigned DATA_BITS_DEF = 16;
    localparam int unsigned SLOT_BITS_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        WAIT_L = 3'd3,
        WAIT_R = 3'd4
    } rx_state_e;

endpackage

// File: rtl/codec_i2s_rx_if.sv
// Word-clock link between the receiver and its LRCK edge detector.
interface codec_i2s_rx_if;

    logic lrck;
    logic rise_c;
    logic fall_c;

    modport master (input lrck, output rise_c, output fall_c);
    modport slave  (output lrck, input rise_c, input fall_c);

endinterface

// File: rtl/codec_i2s_rx_lrck_edge.sv
// codec_lrck_edge: registers LRCK on rising bclk and flags rising/falling edges.
module codec_lrck_edge (
    input  logic           bclk,
    input  logic           req_rstn,
    codec_i2s_rx_if.master eif
);

    logic lrck_q;
    logic lrck_d;

    always_comb begin
        lrck_d = eif.lrck;
    end

    always_ff @(posedge bclk or negedge req_rstn) begin
        if (!req_rstn) begin
            lrck_q <= 1'b0;
        end else begin
            lrck_q <= lrck_d;
        end
    end

    // Edge flags compare the live LRCK with last cycle's value.
    assign eif.rise_c = eif.lrck & ~lrck_q;
    assign eif.fall_c = ~eif.lrck & lrck_q;

endmodule

// File: rtl/codec_i2s_rx.sv
// I2S receiver: captures MSB-first left/right words and presents them as a pair.
// Short-slot reporting on frame_err_o is built when CODEC_I2S_RX_FRAME_CHECK_EN is defined.
module codec_i2s_rx
    import codec_i2s_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned SLOT_BITS = SLOT_BITS_DEF
) (
    input  logic                 bclk,
    input  logic                 req_rstn,
    input  logic                 adc_lrck_i,
    input  logic                 adc_dat_i,
    output logic [DATA_BITS-1:0] sample_data_L_o,
    output logic [DATA_BITS-1:0] sample_data_R_o,
    output logic                 data_ready_o,
    output logic                 frame_err_o
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    if (SLOT_BITS < DATA_BITS + 1) begin : g_slot_chk
        $error("SLOT_BITS must be at least DATA_BITS+1");
    end

    codec_i2s_rx_if lrck_if ();

    assign lrck_if.lrck = adc_lrck_i;

    codec_lrck_edge u_lrck_edge (
        .bclk     (bclk),
        .req_rstn (req_rstn),
        .eif      (lrck_if.master)
    );

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic [DATA_BITS-1:0] hold_l_q, hold_l_d;
    logic [DATA_BITS-1:0] sample_l_q, sample_l_d;
    logic [DATA_BITS-1:0] sample_r_q, sample_r_d;
    logic                 data_ready_q, data_ready_d;
    logic                 frame_err_d;
    logic [IDX_W-1:0]     bit_idx_c;
    logic                 lrck_edge_c;

    // Next-state, bit capture and pair publication.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        hold_l_d     = hold_l_q;
        sample_l_d   = sample_l_q;
        sample_r_d   = sample_r_q;
        data_ready_d = 1'b0;
        frame_err_d  = 1'b0;
        bit_idx_c    = IDX_W'(DATA_BITS - 1) - IDX_W'(cnt_q);
        lrck_edge_c  = lrck_if.rise_c | lrck_if.fall_c;

        unique case (state_q)
            IDLE: begin
                if (lrck_if.fall_c) begin
                    state_d = LEFT;
                    cnt_d   = '0;
                end
            end
            LEFT, RIGHT: begin
                if (lrck_edge_c) begin
                    // Slot ended before the word was complete: drop the frame.
                    state_d     = IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    word_d[bit_idx_c] = adc_dat_i;
                    cnt_d             = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        if (state_q == LEFT) begin
                            state_d  = WAIT_L;
                            hold_l_d = word_d;
                        end else begin
                            state_d      = WAIT_R;
                            sample_l_d   = hold_l_q;
                            sample_r_d   = word_d;
                            data_ready_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_L: begin
                if (lrck_if.rise_c) begin
                    state_d = RIGHT;
                    cnt_d   = '0;
                end else if (lrck_if.fall_c) begin
                    state_d = IDLE;
                end
            end
            WAIT_R: begin
                if (lrck_if.fall_c) begin
                    state_d = LEFT;
                    cnt_d   = '0;
                end else if (lrck_if.rise_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge bclk or negedge req_rstn) begin
        if (!req_rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            hold_l_q     <= '0;
            sample_l_q   <= '0;
            sample_r_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            hold_l_q     <= hold_l_d;
            sample_l_q   <= sample_l_d;
            sample_r_q   <= sample_r_d;
            data_ready_q <= data_ready_d;
        end
    end

`ifdef CODEC_I2S_RX_FRAME_CHECK_EN
    logic frame_err_q;

    always_ff @(posedge bclk or negedge req_rstn) begin
        if (!req_rstn) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err_o = frame_err_q;
`else
    logic unused_frame_err;

    assign unused_frame_err = frame_err_d;
    assign frame_err_o      = 1'b0;
`endif

    assign sample_data_L_o = sample_l_q;
    assign sample_data_R_o = sample_r_q;
    assign data_ready_o    = data_ready_q;

endmodule

// File: tb/tb_codec_i2s_rx.sv
// Randomized + directed bench for codec_i2s_rx with a slot-level reference model.
module tb_codec_i2s_rx;

    localparam int unsigned DB = 16;
    localparam int unsigned SB = 32;
`ifdef CODEC_I2S_RX_FRAME_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam int PIN_PULSE = 0;
    localparam int PIN_ERR   = 1;
    localparam int PIN_ZERO  = 2;

    typedef struct {
        bit            lrck;
        bit            dat;
        bit            rstn;
        bit            rdy;
        bit            err;
        logic [DB-1:0] l;
        logic [DB-1:0] r;
    } cyc_t;

    typedef struct {
        int            cyc;
        int            kind;
        logic [DB-1:0] l;
        logic [DB-1:0] r;
    } pin_t;

    cyc_t stim[$];
    pin_t pins[$];

    logic          bclk = 1'b0;
    logic          req_rstn = 1'b0;
    logic          adc_dat = 1'b0;
    logic [DB-1:0] sample_l, sample_r;
    logic          data_ready, frame_err;

    int  checks = 0;
    int  errors = 0;
    int  cur = 0;
    bit  run = 1'b0;

    // Slot-level model state
    bit            left_valid = 1'b0;
    bit            prev_cap = 1'b0;
    bit            prev_short = 1'b0;
    bit            pend_err = 1'b0;
    logic [DB-1:0] left_word = '0;
    logic [DB-1:0] cur_l = '0;
    logic [DB-1:0] cur_r = '0;

    codec_i2s_rx_if tb_if ();

    assign tb_if.rise_c = 1'b0;
    assign tb_if.fall_c = 1'b0;

    codec_i2s_rx #(.DATA_BITS(DB), .SLOT_BITS(SB)) dut (
        .bclk            (bclk),
        .req_rstn        (req_rstn),
        .adc_lrck_i      (tb_if.lrck),
        .adc_dat_i       (adc_dat),
        .sample_data_L_o (sample_l),
        .sample_data_R_o (sample_r),
        .data_ready_o    (data_ready),
        .frame_err_o     (frame_err)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cur, act, exp);
        end
    endtask

    // One LRCK half-period: pol 0 = left. Cycle 0 is the delay bit, word bits follow MSB first.
    task automatic add_slot(input bit pol, input int n, input logic [DB-1:0] w, input bit ones,
                            input int rst_at, input int rst_len, output int pulse_cyc);
        int            base;
        bit            cap;
        bit            short_s;
        logic [DB-1:0] sh;
        cyc_t          c;
        base      = stim.size();
        short_s   = (n < int'(DB) + 1);
        sh        = w;
        pulse_cyc = -1;
        if (rst_len > 0)   cap = 1'b0;
        else if (pol == 0) cap = !(prev_cap && prev_short);
        else               cap = left_valid;
        for (int k = 0; k < n; k++) begin
            c.lrck = pol;
            if (k >= 1 && k <= int'(DB)) begin
                c.dat = sh[DB-1];
                sh    = sh << 1;
            end else begin
                c.dat = ones ? 1'b1 : 1'($urandom_range(0, 1));
            end
            c.rstn = !(rst_len > 0 && k >= rst_at && k < rst_at + rst_len);
            if (!c.rstn) begin
                cur_l = '0;
                cur_r = '0;
            end
            c.rdy = 1'b0;
            c.err = (k == 0) && pend_err && CHK_EN && c.rstn;
            if (cap && !short_s && pol && k == int'(DB)) begin
                cur_l     = left_word;
                cur_r     = w;
                c.rdy     = 1'b1;
                pulse_cyc = base + k;
            end
            c.l = cur_l;
            c.r = cur_r;
            stim.push_back(c);
        end
        pend_err = cap && short_s;
        if (pol == 0) begin
            left_valid = cap && !short_s;
            left_word  = w;
        end else begin
            left_valid = 1'b0;
        end
        prev_cap   = cap;
        prev_short = short_s;
    endtask

    task automatic add_pin(input int cyc, input int kind, input logic [DB-1:0] l, input logic [DB-1:0] r);
        pin_t p;
        p.cyc  = cyc;
        p.kind = kind;
        p.l    = l;
        p.r    = r;
        pins.push_back(p);
    endtask

    // Compare process: model every cycle plus literal pins.
    initial begin
        forever begin
            @(posedge bclk);
            #1;
            if (run) begin
                check("data_ready", DB'(data_ready), DB'(stim[cur].rdy));
                check("frame_err", DB'(frame_err), DB'(stim[cur].err));
                check("sample_L", sample_l, stim[cur].l);
                check("sample_R", sample_r, stim[cur].r);
                foreach (pins[i]) begin
                    if (pins[i].cyc == cur) begin
                        if (pins[i].kind == PIN_PULSE) begin
                            check("pin_ready", DB'(data_ready), DB'(1));
                            check("pin_L", sample_l, pins[i].l);
                            check("pin_R", sample_r, pins[i].r);
                        end else if (pins[i].kind == PIN_ERR) begin
                            check("pin_err", DB'(frame_err), DB'(CHK_EN));
                            check("pin_err_noready", DB'(data_ready), DB'(0));
                        end else begin
                            check("pin_rst_L", sample_l, DB'(0));
                            check("pin_rst_R", sample_r, DB'(0));
                            check("pin_rst_ready", DB'(data_ready), DB'(0));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int p, p1, s, n, ra, rl, rv;
        bit pol;
        tb_if.lrck = 1'b0;

        add_slot(0, 4, '0, 0, 0, 4, p);
        add_pin(2, PIN_ZERO, '0, '0);
        add_slot(1, 20, 16'h5A5A, 0, 0, 0, p);
        // Basic pair
        add_slot(0, SB, 16'h1234, 0, 0, 0, p);
        add_slot(1, SB, 16'hABCD, 0, 0, 0, p);
        add_pin(p, PIN_PULSE, 16'h1234, 16'hABCD);
        // Back-to-back frames, 64 bclk apart
        add_slot(0, SB, 16'h8000, 0, 0, 0, p);
        add_slot(1, SB, 16'h7FFF, 0, 0, 0, p1);
        add_pin(p1, PIN_PULSE, 16'h8000, 16'h7FFF);
        add_slot(0, SB, 16'hFFFF, 0, 0, 0, p);
        add_slot(1, SB, 16'h0001, 0, 0, 0, p);
        add_pin(p1 + 64, PIN_PULSE, 16'hFFFF, 16'h0001);
        // Trailing ones ignored
        add_slot(0, SB, 16'h0F0F, 1, 0, 0, p);
        add_slot(1, SB, 16'h3C3C, 1, 0, 0, p);
        add_pin(p, PIN_PULSE, 16'h0F0F, 16'h3C3C);
        // Short left slot after 10 bits
        s = stim.size();
        add_slot(0, 11, 16'hDEAD, 0, 0, 0, p);
        add_pin(s + 11, PIN_ERR, '0, '0);
        add_slot(1, SB, 16'hBEEF, 0, 0, 0, p);
        add_slot(0, SB, 16'h1111, 0, 0, 0, p);
        add_slot(1, SB, 16'h2222, 0, 0, 0, p);
        add_pin(p, PIN_PULSE, 16'h1111, 16'h2222);
        // Reset for 3 cycles mid-left-word
        s = stim.size();
        add_slot(0, SB, 16'h3333, 0, 5, 3, p);
        add_pin(s + 5, PIN_ZERO, '0, '0);
        add_pin(s + 9, PIN_ZERO, '0, '0);
        add_slot(1, SB, 16'h4444, 0, 0, 0, p);
        add_slot(0, SB, 16'h5555, 0, 0, 0, p);
        add_slot(1, SB, 16'h6666, 0, 0, 0, p);
        add_pin(p, PIN_PULSE, 16'h5555, 16'h6666);
        // Reset released with LRCK high mid-right-slot
        add_slot(0, SB, 16'h7777, 0, 0, 0, p);
        add_slot(1, SB, 16'h8888, 0, 4, 3, p);
        add_slot(0, SB, 16'h9999, 0, 0, 0, p);
        add_slot(1, SB, 16'hAAAA, 0, 0, 0, p);
        add_pin(p, PIN_PULSE, 16'h9999, 16'hAAAA);
        // Randomized slots: mostly nominal, some long, some short, rare resets
        pol = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pol = ~pol;
            rv  = int'($urandom_range(0, 99));
            if (rv < 12)      n = int'($urandom_range(2, DB));
            else if (rv < 30) n = int'($urandom_range(DB + 1, 40));
            else              n = int'(SB);
            ra = 0;
            rl = 0;
            if (pol == 0 && n > int'(DB) && $urandom_range(0, 14) == 0) begin
                rl = int'($urandom_range(1, 3));
                ra = int'($urandom_range(1, n - rl));
            end
            add_slot(pol, n, DB'($urandom), 1'($urandom_range(0, 1)), ra, rl, p);
        end
        add_slot(~pol, 20, DB'($urandom), 0, 0, 0, p);

        for (int c = 0; c < stim.size(); c++) begin
            @(negedge bclk);
            tb_if.lrck = stim[c].lrck;
            adc_dat    = stim[c].dat;
            req_rstn   = stim[c].rstn;
            cur        = c;
            run        = 1'b1;
        end
        @(negedge bclk);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
